mips_irq_ctl: RTL and testbench
===============================

Name: mips_irq_ctl

Overview:
- Vectored interrupt controller between the device block's interrupt sources (timer, key1, key2, …) and the CPU interrupt input.
- Synchronises and edge-detects each source, latches pending requests and applies per-source and global enables.
- Selects the highest-priority pending source and runs a request/acknowledge/end-of-interrupt handshake with the core, presenting the selected source's vector address.
- Software-visible registers sit on the device bus; the device block decodes addresses and drives the wr/rd strobes.

Parameters:
NSRC, 3, number of interrupt sources (1..8); source 0 has highest priority.
VEC_RST, 32'h0000_0000, reset value of every vector register.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous active-low reset.
src_i  in  NSRC  raw interrupt lines (level, asynchronous to clk for keys).
reg_wr  in  1  register write strobe, one cycle.
reg_rd  in  1  register read strobe, one cycle.
reg_sel  in  4  register index (see map).
din  in  32  write data.
dout  out  32  read data, registered.
irq_req_o  out  1  interrupt request to CPU.
irq_addr_o  out  32  vector of selected source; valid whenever irq_req_o=1.
irq_ack_i  in  1  CPU acknowledge, one-cycle pulse.
irq_busy_o  out  1  high in SERVICE state.

Behaviour:
- Reset (rst=0, asynchronous): dout=0, irq_req_o=0, irq_addr_o=0, irq_busy_o=0, ENABLE=0, PENDING=0, all VECTORs=VEC_RST, sync flops=0, state=IDLE.
- Input stage: per source, 2-FF synchroniser, then rising-edge detect; edge pulse appears 3 cycles after the src_i rise. Held levels produce one edge only.
- PENDING[i] set by edge pulse regardless of ENABLE. Cleared by acknowledge of source i or by software W1C. If a set and a clear hit the same bit in the same cycle, set wins.
- Register map (reg_sel):
  - 0 CTRL: bit0 global enable.
  - 1 ENABLE: bits[NSRC-1:0].
  - 2 PENDING: read; write-1-to-clear.
  - 3 STATUS: read-only {state[1:0] at bits[9:8], in-service id at bits[2:0]}.
  - 4 EOI: write, any data.
  - 8+i VECTOR[i].
- Unmapped reads return 0; unmapped writes are ignored. dout is updated one cycle after reg_rd and is 0 in cycles without reg_rd.
- Eligible set = PENDING & ENABLE, gated by CTRL[0]. Selected source = lowest index in the eligible set.
- State machine:
  - IDLE: if the eligible set is non-empty, latch the selected id and its VECTOR into irq_addr_o, assert irq_req_o next cycle, and go to REQ.
  - REQ: irq_req_o=1; the id and irq_addr_o are frozen even if a higher-priority source becomes pending (no preemption). On irq_ack_i: clear PENDING[id], drop irq_req_o the next cycle, go to SERVICE.
  - REQ cancel: if the latched id stops being eligible (disabled, W1C, or global enable cleared) before ack, drop irq_req_o and return to IDLE; re-arbitration starts the following cycle.
  - SERVICE: irq_busy_o=1, no new request. An EOI write returns to IDLE; arbitration occurs in the IDLE cycle, so minimum gap is 1 cycle.
  - irq_ack_i outside REQ and EOI outside SERVICE are ignored.
- Latency: eligible in IDLE → irq_req_o high after 1 cycle; src_i rise → irq_req_o high after 5 cycles worst case with all enables set.
- Register write to VECTOR[id] during REQ does not change irq_addr_o.
- Reset mid-operation returns to IDLE immediately; pending requests are lost.

Decomposition:
- Add to mips789_defs.v: register index constants (IRQ_CTRL … IRQ_VEC0), state encodings (IRQ_IDLE=0, IRQ_REQ=1, IRQ_SVC=2) and STATUS field positions.
- One sub-module, irq_src_sync: synchroniser plus rising-edge detector, instantiated NSRC times through a generate loop.
- Arbitration is a priority encoder function inside mips_irq_ctl.

Test Plan:
- Reset, then read all registers → CTRL/ENABLE/PENDING=0, VECTOR[i]=0, STATUS=0, irq_req_o=0.
- VEC1=32'h0000_0200, ENABLE=3'b010, CTRL=1, pulse src_i[1] → PENDING=3'b010, irq_req_o high 5 cycles after the rise with irq_addr_o=32'h200; ack → PENDING=0, STATUS state=2, id=1; EOI → state=0.
- src_i[0] and src_i[2] rise in the same cycle, all enabled, VEC0=32'h100, VEC2=32'h300 → first request addr 32'h100; after ack+EOI, second request addr 32'h300.
- In REQ for source 2, raise src_i[0] → irq_addr_o stays 32'h300 until ack; source 0 is served after EOI.
- In REQ, write ENABLE=0 → irq_req_o drops within 1 cycle, state=IDLE, PENDING bit retained; re-enable → request re-issued.
- Assert rst in SERVICE → outputs are reset values in the same cycle; ack and EOI written with no request pending are ignored (STATUS=0).

Source files
------------

// File: rtl/mips_irq_ctl_pkg.sv
// rtl/mips_irq_ctl_pkg.sv - register indices, state encodings and STATUS field positions
package mips_irq_ctl_pkg;

    localparam logic [3:0] REG_CTRL    = 4'd0;
    localparam logic [3:0] REG_ENABLE  = 4'd1;
    localparam logic [3:0] REG_PENDING = 4'd2;
    localparam logic [3:0] REG_STATUS  = 4'd3;
    localparam logic [3:0] REG_EOI     = 4'd4;
    localparam logic [3:0] REG_VEC0    = 4'd8;

    localparam int STATUS_STATE_LSB = 8;
    localparam int STATUS_ID_LSB    = 0;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SVC  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/mips_irq_ctl_if.sv
// rtl/mips_irq_ctl_if.sv - register bus and CPU interrupt handshake bundle
// Register side: reg_wr/reg_rd one-cycle strobes, reg_sel index, din write data,
// dout registered read data. CPU side: irq_req_o/irq_addr_o request + vector,
// irq_ack_i acknowledge pulse, irq_busy_o high while a source is in service.
interface mips_irq_ctl_if;
    logic        reg_wr;
    logic        reg_rd;
    logic [3:0]  reg_sel;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq_req_o;
    logic [31:0] irq_addr_o;
    logic        irq_ack_i;
    logic        irq_busy_o;

    modport master (
        output reg_wr, reg_rd, reg_sel, din, irq_ack_i,
        input  dout, irq_req_o, irq_addr_o, irq_busy_o
    );

    modport slave (
        input  reg_wr, reg_rd, reg_sel, din, irq_ack_i,
        output dout, irq_req_o, irq_addr_o, irq_busy_o
    );
endinterface

// File: rtl/mips_irq_ctl_src_sync.sv
// rtl/mips_irq_ctl_src_sync.sv - 2-FF synchroniser plus registered rising-edge detector
// Ports: clk, rst (async active-low), src raw level, pulse one-cycle edge pulse
// three cycles after the src rise.
module irq_src_sync (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic pulse
);
    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= src;
            s2    <= s1;
            s3    <= s2;
            // registered so the pulse leaves on a clean flop output
            pulse <= s2 & ~s3;
        end
    end
endmodule

// File: rtl/mips_irq_ctl.sv
// rtl/mips_irq_ctl.sv - vectored interrupt controller with req/ack/EOI handshake
// Ports: clk, rst (async active-low), src_i[NSRC] raw interrupt lines,
// bus (slave modport) carrying the register strobes and CPU handshake.
module mips_irq_ctl
    import mips_irq_ctl_pkg::*;
#(
    parameter int          NSRC    = 3,
    parameter logic [31:0] VEC_RST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src_i,
    mips_irq_ctl_if.slave     bus
);
    irq_state_t        state_q, state_d;
    logic              gen_q;
    logic [NSRC-1:0]   en_q, pend_q;
    logic [31:0]       vec_q [NSRC];
    logic [2:0]        id_q;
    logic [31:0]       addr_q;
    logic [NSRC-1:0]   src_edge, elig, id_mask, clr;
    logic [2:0]        sel_id;
    logic [31:0]       sel_vec, rd_data;
    logic              id_elig, ack_take, eoi_wr, w1c_wr;

    function automatic logic [2:0] prio_enc(input logic [NSRC-1:0] v);
        prio_enc = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) prio_enc = 3'(i);
        end
    endfunction

    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        irq_src_sync u_sync (
            .clk   (clk),
            .rst   (rst),
            .src   (src_i[g]),
            .pulse (src_edge[g])
        );
    end

    assign elig     = gen_q ? (pend_q & en_q) : '0;
    assign sel_id   = prio_enc(elig);
    assign eoi_wr   = bus.reg_wr && (bus.reg_sel == REG_EOI);
    assign w1c_wr   = bus.reg_wr && (bus.reg_sel == REG_PENDING);
    assign id_elig  = |(elig & id_mask);
    // a cancel in the same cycle as ack wins: the source is no longer eligible
    assign ack_take = (state_q == IRQ_REQ) && bus.irq_ack_i && id_elig;
    assign clr      = (w1c_wr ? bus.din[NSRC-1:0] : '0) | (ack_take ? id_mask : '0);

    always_comb begin
        id_mask = '0;
        sel_vec = '0;
        for (int i = 0; i < NSRC; i++) begin
            id_mask[i] = (id_q == 3'(i));
            if (sel_id == 3'(i)) sel_vec = vec_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE: if (|elig) state_d = IRQ_REQ;
            IRQ_REQ: begin
                if (!id_elig)     state_d = IRQ_IDLE;
                else if (ack_take) state_d = IRQ_SVC;
            end
            IRQ_SVC:  if (eoi_wr) state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (bus.reg_sel)
            REG_CTRL:    rd_data[0] = gen_q;
            REG_ENABLE:  rd_data[NSRC-1:0] = en_q;
            REG_PENDING: rd_data[NSRC-1:0] = pend_q;
            REG_STATUS: begin
                rd_data[STATUS_STATE_LSB +: 2] = state_q;
                rd_data[STATUS_ID_LSB +: 3]    = id_q;
            end
            default: begin
                for (int i = 0; i < NSRC; i++) begin
                    if (bus.reg_sel == REG_VEC0 + 4'(i)) rd_data = vec_q[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IRQ_IDLE;
            gen_q    <= 1'b0;
            en_q     <= '0;
            pend_q   <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            bus.dout <= '0;
        end else begin
            state_q <= state_d;
            // id and vector freeze here until the next IDLE arbitration
            if (state_q == IRQ_IDLE && |elig) begin
                id_q   <= sel_id;
                addr_q <= sel_vec;
            end
            // set after clear: a new edge is never lost to a simultaneous clear
            pend_q <= (pend_q & ~clr) | src_edge;
            if (bus.reg_wr && bus.reg_sel == REG_CTRL)   gen_q <= bus.din[0];
            if (bus.reg_wr && bus.reg_sel == REG_ENABLE) en_q  <= bus.din[NSRC-1:0];
            bus.dout <= bus.reg_rd ? rd_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSRC; i++) vec_q[i] <= VEC_RST;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (bus.reg_wr && bus.reg_sel == REG_VEC0 + 4'(i)) vec_q[i] <= bus.din;
            end
        end
    end

    assign bus.irq_req_o  = (state_q == IRQ_REQ);
    assign bus.irq_busy_o = (state_q == IRQ_SVC);
    assign bus.irq_addr_o = addr_q;
endmodule

// File: tb/tb_mips_irq_ctl.sv
// tb/tb_mips_irq_ctl.sv - directed self-checking bench for mips_irq_ctl
module tb_mips_irq_ctl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] src_i = 3'b000;
    int checks   = 0;
    int failures = 0;
    logic [31:0] rv;

    mips_irq_ctl_if bus();

    mips_irq_ctl #(.NSRC(3), .VEC_RST(32'h0000_0000)) dut (
        .clk   (clk),
        .rst   (rst),
        .src_i (src_i),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] sel, input logic [31:0] d);
        bus.reg_wr  = 1'b1;
        bus.reg_sel = sel;
        bus.din     = d;
        step();
        bus.reg_wr  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] sel, output logic [31:0] d);
        bus.reg_rd  = 1'b1;
        bus.reg_sel = sel;
        step();
        bus.reg_rd  = 1'b0;
        d = bus.dout;
    endtask

    task automatic ack();
        bus.irq_ack_i = 1'b1;
        step();
        bus.irq_ack_i = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.irq_req_o) break;
            step();
        end
        chk(tag, {31'd0, bus.irq_req_o}, 32'd1);
    endtask

    initial begin
        bus.reg_wr = 0; bus.reg_rd = 0; bus.reg_sel = 0; bus.din = 0; bus.irq_ack_i = 0;
        #22 rst = 1'b1;
        step();

        // reset state
        chk("rst_req",  {31'd0, bus.irq_req_o},  32'd0);
        chk("rst_busy", {31'd0, bus.irq_busy_o}, 32'd0);
        chk("rst_addr", bus.irq_addr_o, 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        rd(4'd0,  rv); chk("rst_ctrl",    rv, 32'd0);
        rd(4'd1,  rv); chk("rst_enable",  rv, 32'd0);
        rd(4'd2,  rv); chk("rst_pending", rv, 32'd0);
        rd(4'd3,  rv); chk("rst_status",  rv, 32'd0);
        rd(4'd8,  rv); chk("rst_vec0",    rv, 32'd0);
        rd(4'd9,  rv); chk("rst_vec1",    rv, 32'd0);
        rd(4'd10, rv); chk("rst_vec2",    rv, 32'd0);

        // single source, latency and handshake
        wr(4'd9, 32'h0000_0200);
        wr(4'd1, 32'h2);
        wr(4'd0, 32'h1);
        rd(4'd15, rv); chk("unmapped_rd", rv, 32'd0);
        chk("dout_idle", bus.dout, 32'd0);
        src_i = 3'b010;
        for (int i = 0; i < 4; i++) step();
        chk("lat_req_early", {31'd0, bus.irq_req_o}, 32'd0);
        step();
        chk("lat_req_5", {31'd0, bus.irq_req_o}, 32'd1);
        chk("lat_addr", bus.irq_addr_o, 32'h200);
        src_i = 3'b000;
        rd(4'd2, rv); chk("pend_src1", rv, 32'h2);
        ack();
        chk("ack_req_drop", {31'd0, bus.irq_req_o}, 32'd0);
        chk("ack_busy", {31'd0, bus.irq_busy_o}, 32'd1);
        rd(4'd2, rv); chk("ack_pend_clr", rv, 32'd0);
        rd(4'd3, rv); chk("svc_status", rv, 32'h0000_0201);
        wr(4'd4, 32'h0);
        rd(4'd3, rv); chk("eoi_state", {30'd0, rv[9:8]}, 32'd0);

        // simultaneous sources, priority order
        wr(4'd8,  32'h100);
        wr(4'd10, 32'h300);
        wr(4'd1,  32'h7);
        src_i = 3'b101;
        wait_req("pri_req0");
        chk("pri_addr0", bus.irq_addr_o, 32'h100);
        src_i = 3'b000;
        ack();
        wr(4'd4, 32'h0);
        wait_req("pri_req2");
        chk("pri_addr2", bus.irq_addr_o, 32'h300);

        // no preemption while in REQ for source 2
        src_i = 3'b001;
        for (int i = 0; i < 6; i++) step();
        src_i = 3'b000;
        chk("nopre_addr", bus.irq_addr_o, 32'h300);
        chk("nopre_req", {31'd0, bus.irq_req_o}, 32'd1);
        wr(4'd10, 32'h333);
        chk("vecwr_frozen", bus.irq_addr_o, 32'h300);
        rd(4'd2, rv); chk("nopre_pend", rv, 32'h5);
        ack();
        wr(4'd4, 32'h0);
        wait_req("nopre_req0");
        chk("nopre_addr0", bus.irq_addr_o, 32'h100);
        ack();
        wr(4'd4, 32'h0);

        // cancel by disabling in REQ, then re-issue
        src_i = 3'b100;
        wait_req("cancel_req");
        src_i = 3'b000;
        wr(4'd1, 32'h0);
        step();
        chk("cancel_drop", {31'd0, bus.irq_req_o}, 32'd0);
        rd(4'd3, rv); chk("cancel_state", {30'd0, rv[9:8]}, 32'd0);
        rd(4'd2, rv); chk("cancel_pend", rv, 32'h4);
        wr(4'd1, 32'h4);
        wait_req("reissue_req");
        chk("reissue_addr", bus.irq_addr_o, 32'h333);

        // reset in SERVICE
        ack();
        chk("svc_busy", {31'd0, bus.irq_busy_o}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.irq_busy_o}, 32'd0);
        chk("arst_req",  {31'd0, bus.irq_req_o},  32'd0);
        chk("arst_addr", bus.irq_addr_o, 32'd0);
        chk("arst_dout", bus.dout, 32'd0);
        #3 rst = 1'b1;
        step();
        ack();
        wr(4'd4, 32'h0);
        chk("stray_req", {31'd0, bus.irq_req_o}, 32'd0);
        rd(4'd3, rv);  chk("stray_status", rv, 32'd0);
        rd(4'd1, rv);  chk("arst_enable", rv, 32'd0);
        rd(4'd10, rv); chk("arst_vec2", rv, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
